// File: rtl/dm_port_arbiter.sv
// Round-robin arbiter sharing the single data-memory port between the CPU M-stage (m0) and a
// DMA/debug master (m1), with locked bursts, registered ownership and a registered response path.
module dm_port_arbiter #(
    parameter int unsigned DM_WORDS  = 4096,
    parameter int unsigned BURST_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        m0_req,
    input  logic        m0_lock,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_byteen,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_rerr,

    input  logic        m1_req,
    input  logic        m1_lock,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_byteen,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_rerr,

    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byteen,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    localparam logic [3:0] BurstLast = 4'(BURST_MAX - 1);

    state_e      state_q, state_d;
    logic        owner_q, owner_d;
    logic        rr_last_q, rr_last_d;
    logic [3:0]  beat_cnt_q, beat_cnt_d;

    logic        resp_valid_q;
    logic        resp_owner_q;
    logic        resp_err_q;
    logic [31:0] resp_data_q;

    logic        own_req;
    logic        own_lock;
    logic [31:0] own_addr;
    logic [31:0] own_wdata;
    logic [3:0]  own_byteen;
    logic        oth_req;
    logic        busy;
    logic        beat;
    logic        in_range;
    logic        tenure_end;

    // Owner-selected master view; the non-owner only matters for handoff.
    always_comb begin
        own_req    = m0_req;
        own_lock   = m0_lock;
        own_addr   = m0_addr;
        own_wdata  = m0_wdata;
        own_byteen = m0_byteen;
        oth_req    = m1_req;
        if (owner_q) begin
            own_req    = m1_req;
            own_lock   = m1_lock;
            own_addr   = m1_addr;
            own_wdata  = m1_wdata;
            own_byteen = m1_byteen;
            oth_req    = m0_req;
        end
    end

    assign busy     = (state_q == StBusy);
    assign beat     = busy && own_req;
    assign in_range = ({2'b00, own_addr[31:2]} < DM_WORDS);

    assign m0_gnt = beat && !owner_q;
    assign m1_gnt = beat && owner_q;

    assign mem_addr   = busy ? {own_addr[31:2], 2'b00} : 32'h0;
    assign mem_wdata  = busy ? own_wdata : 32'h0;
    assign mem_byteen = (beat && in_range) ? own_byteen : 4'h0;

    // A dropped request ends the tenure just like an unlocked or final beat.
    assign tenure_end = !own_req || !own_lock || (beat_cnt_q == BurstLast);

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_last_d  = rr_last_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            StIdle: begin
                if (m0_req || m1_req) begin
                    state_d    = StBusy;
                    beat_cnt_d = 4'd0;
                    owner_d    = (m0_req && m1_req) ? !rr_last_q : m1_req;
                end
            end
            StBusy: begin
                if (beat) begin
                    beat_cnt_d = beat_cnt_q + 4'd1;
                end
                if (tenure_end) begin
                    rr_last_d = owner_q;
                    if (oth_req) begin
                        owner_d    = !owner_q;
                        beat_cnt_d = 4'd0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            owner_q    <= 1'b0;
            rr_last_q  <= 1'b1;
            beat_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_last_q  <= rr_last_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Writes and out-of-range beats return zero data.
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_valid_q <= 1'b0;
            resp_owner_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_data_q  <= 32'h0;
        end else begin
            resp_valid_q <= beat;
            resp_owner_q <= owner_q;
            resp_err_q   <= beat && !in_range;
            resp_data_q  <= (beat && in_range && (own_byteen == 4'h0)) ? mem_rdata : 32'h0;
        end
    end

    assign m0_rvalid = resp_valid_q && !resp_owner_q;
    assign m1_rvalid = resp_valid_q && resp_owner_q;
    assign m0_rdata  = m0_rvalid ? resp_data_q : 32'h0;
    assign m1_rdata  = m1_rvalid ? resp_data_q : 32'h0;
    assign m0_rerr   = m0_rvalid && resp_err_q;
    assign m1_rerr   = m1_rvalid && resp_err_q;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Bench for dm_port_arbiter: directed scenarios plus randomized traffic, all checked against a
// behavioural model of the arbitration rules and a reference memory image.
module tb_dm_port_arbiter;

    localparam int unsigned DM_WORDS  = 4096;
    localparam int unsigned BURST_MAX = 4;
    localparam int unsigned AW        = $clog2(DM_WORDS);

    logic        clk;
    logic        reset;
    logic        m0_req, m0_lock, m1_req, m1_lock;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_byteen, m1_byteen;
    logic        m0_gnt, m0_rvalid, m0_rerr, m1_gnt, m1_rvalid, m1_rerr;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_byteen;

    dm_port_arbiter #(
        .DM_WORDS  (DM_WORDS),
        .BURST_MAX (BURST_MAX)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .m0_req     (m0_req),
        .m0_lock    (m0_lock),
        .m0_addr    (m0_addr),
        .m0_wdata   (m0_wdata),
        .m0_byteen  (m0_byteen),
        .m0_gnt     (m0_gnt),
        .m0_rvalid  (m0_rvalid),
        .m0_rdata   (m0_rdata),
        .m0_rerr    (m0_rerr),
        .m1_req     (m1_req),
        .m1_lock    (m1_lock),
        .m1_addr    (m1_addr),
        .m1_wdata   (m1_wdata),
        .m1_byteen  (m1_byteen),
        .m1_gnt     (m1_gnt),
        .m1_rvalid  (m1_rvalid),
        .m1_rdata   (m1_rdata),
        .m1_rerr    (m1_rerr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_byteen (mem_byteen),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory attached to the DUT port, and the model's own image of what it should hold.
    logic [31:0] mem     [DM_WORDS];
    logic [31:0] ref_mem [DM_WORDS];

    always_comb begin
        mem_rdata = 32'h0;
        if (mem_addr[31:2] < 30'(DM_WORDS)) mem_rdata = mem[mem_addr[AW+1:2]];
    end

    always @(posedge clk) begin
        if (mem_addr[31:2] < 30'(DM_WORDS)) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_byteen[b]) mem[mem_addr[AW+1:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Model state: who holds the port, how many beats this tenure, who was served last.
    bit          m_busy, m_owner, m_rr_last;
    int          m_beats;
    bit          e_rv0, e_rv1, e_err;
    logic [31:0] e_rd;

    // Values seen in the most recent step, for directed checks.
    logic        s_gnt0, s_gnt1, s_rv0, s_rv1, s_rerr0;
    logic [31:0] s_rd0;
    logic [3:0]  s_be;

    task automatic model_reset();
        m_busy    = 1'b0;
        m_owner   = 1'b0;
        m_rr_last = 1'b1;
        m_beats   = 0;
        e_rv0     = 1'b0;
        e_rv1     = 1'b0;
    endtask

    task automatic idle_inputs();
        m0_req = 0; m0_lock = 0; m0_addr = 0; m0_wdata = 0; m0_byteen = 0;
        m1_req = 0; m1_lock = 0; m1_addr = 0; m1_wdata = 0; m1_byteen = 0;
    endtask

    // One clock cycle: inputs are already set; check outputs against the model, advance the model.
    task automatic step(input bit rst);
        bit          req [2];
        bit          lock [2];
        logic [31:0] a [2];
        logic [31:0] wd [2];
        logic [3:0]  be [2];
        logic [29:0] widx;
        bit          k, beat, inr, endt;
        reset = rst;
        req[0] = m0_req; lock[0] = m0_lock; a[0] = m0_addr; wd[0] = m0_wdata; be[0] = m0_byteen;
        req[1] = m1_req; lock[1] = m1_lock; a[1] = m1_addr; wd[1] = m1_wdata; be[1] = m1_byteen;
        #1;
        s_gnt0 = m0_gnt; s_gnt1 = m1_gnt; s_rv0 = m0_rvalid; s_rv1 = m1_rvalid;
        s_rd0 = m0_rdata; s_rerr0 = m0_rerr; s_be = mem_byteen;

        check("rvalid0", m0_rvalid, e_rv0);
        check("rvalid1", m1_rvalid, e_rv1);
        if (e_rv0) begin
            check("rdata0", m0_rdata, e_rd);
            check("rerr0", m0_rerr, e_err);
        end
        if (e_rv1) begin
            check("rdata1", m1_rdata, e_rd);
            check("rerr1", m1_rerr, e_err);
        end

        k    = m_owner;
        beat = m_busy && req[k];
        check("gnt0", m0_gnt, beat && !k);
        check("gnt1", m1_gnt, beat && k);
        e_rv0 = 1'b0;
        e_rv1 = 1'b0;
        if (!m_busy) begin
            check("idle_mem_addr", mem_addr, 32'h0);
            check("idle_mem_wdata", mem_wdata, 32'h0);
            check("idle_mem_byteen", mem_byteen, 32'h0);
        end else if (!beat) begin
            check("nobeat_mem_byteen", mem_byteen, 32'h0);
        end else begin
            widx = a[k][31:2];
            inr  = widx < 30'(DM_WORDS);
            check("mem_addr", mem_addr, {a[k][31:2], 2'b00});
            check("mem_wdata", mem_wdata, wd[k]);
            check("mem_byteen", mem_byteen, inr ? be[k] : 4'h0);
            e_rv0 = !k;
            e_rv1 = k;
            e_err = !inr;
            e_rd  = (inr && be[k] == 4'h0) ? ref_mem[widx[AW-1:0]] : 32'h0;
            if (inr) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[k][b]) ref_mem[widx[AW-1:0]][8*b +: 8] = wd[k][8*b +: 8];
                end
            end
        end

        if (!m_busy) begin
            if (req[0] || req[1]) begin
                m_busy  = 1'b1;
                m_beats = 0;
                m_owner = (req[0] && req[1]) ? !m_rr_last : req[1];
            end
        end else begin
            if (beat) m_beats++;
            endt = !beat || !lock[k] || (m_beats == int'(BURST_MAX));
            if (endt) begin
                m_rr_last = k;
                if (req[!k]) begin
                    m_owner = !k;
                    m_beats = 0;
                end else begin
                    m_busy = 1'b0;
                end
            end
        end
        if (rst) model_reset();
        @(negedge clk);
    endtask

    int          seq [$];
    int          m0_done, m1_done;
    logic [31:0] word0;

    initial begin
        for (int i = 0; i < int'(DM_WORDS); i++) begin
            mem[i]     = 32'(i) * 32'h9E37_79B9;
            ref_mem[i] = 32'(i) * 32'h9E37_79B9;
        end
        mem[4] = 32'hDEAD_BEEF; ref_mem[4] = 32'hDEAD_BEEF;
        mem[8] = 32'h1122_3344; ref_mem[8] = 32'h1122_3344;

        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        #1;
        check("rst_gnt0", m0_gnt, 0);
        check("rst_gnt1", m1_gnt, 0);
        check("rst_rvalid0", m0_rvalid, 0);
        check("rst_rvalid1", m1_rvalid, 0);
        check("rst_rdata0", m0_rdata, 0);
        check("rst_rerr1", m1_rerr, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_byteen", mem_byteen, 0);
        @(negedge clk);

        // Single read by m0 after reset.
        m0_req = 1; m0_addr = 32'h10;
        step(0);
        check("t1_idle_gnt0", s_gnt0, 0);
        step(0);
        check("t1_gnt0", s_gnt0, 1);
        check("t1_byteen", s_be, 0);
        idle_inputs();
        step(0);
        check("t1_rvalid0", s_rv0, 1);
        check("t1_rdata0", s_rd0, 32'hDEAD_BEEF);

        // Both masters issue single writes every cycle: strict alternation.
        idle_inputs();
        step(1);
        m0_req = 1; m0_addr = 32'h100; m0_wdata = 32'hA0A0_0001; m0_byteen = 4'hF;
        m1_req = 1; m1_addr = 32'h200; m1_wdata = 32'hB1B1_0002; m1_byteen = 4'hF;
        step(0);
        for (int i = 1; i <= 4; i++) begin
            step(0);
            check($sformatf("t2_gnt0_%0d", i), s_gnt0, (i % 2) == 1);
            check($sformatf("t2_gnt1_%0d", i), s_gnt1, (i % 2) == 0);
        end
        idle_inputs();
        step(0);
        check("t2_mem64", mem[64], 32'hA0A0_0001);
        check("t2_mem128", mem[128], 32'hB1B1_0002);

        // Locked m1 burst of 6 with m0 waiting: 4 beats, forced handoff, then the rest.
        step(1);
        m0_done = 0; m1_done = 0;
        seq.delete();
        for (int i = 0; i < 20 && (m0_done < 1 || m1_done < 6); i++) begin
            m1_req = m1_done < 6; m1_lock = m1_done < 5; m1_byteen = 4'hF;
            m1_addr = 32'h300 + 32'(m1_done) * 4; m1_wdata = 32'h3300_0000 + 32'(m1_done);
            m0_req = (i >= 1) && (m0_done < 1); m0_lock = 0; m0_byteen = 4'hF;
            m0_addr = 32'h400; m0_wdata = 32'h0400_0400;
            step(0);
            if (s_gnt1) begin seq.push_back(1); m1_done++; end
            if (s_gnt0) begin seq.push_back(0); m0_done++; end
        end
        idle_inputs();
        step(0);
        check("t3_beats", seq.size(), 7);
        for (int i = 0; i < 7 && i < seq.size(); i++) begin
            check($sformatf("t3_owner_%0d", i), seq[i], (i == 4) ? 0 : 1);
        end

        // Out-of-range write is blocked and flagged.
        word0 = mem[0];
        m0_req = 1; m0_addr = 32'h4000; m0_wdata = 32'hCAFE_F00D; m0_byteen = 4'hF;
        step(0);
        step(0);
        check("t4_gnt0", s_gnt0, 1);
        check("t4_byteen", s_be, 0);
        idle_inputs();
        step(0);
        check("t4_rvalid0", s_rv0, 1);
        check("t4_rerr0", s_rerr0, 1);
        check("t4_rdata0", s_rd0, 0);
        check("t4_mem0", mem[0], word0);

        // Byte-lane write merges into the existing word.
        m0_req = 1; m0_addr = 32'h20; m0_wdata = 32'h00AB_0000; m0_byteen = 4'b0100;
        step(0);
        step(0);
        check("t5_byteen", s_be, 4'b0100);
        idle_inputs();
        step(0);
        m0_req = 1; m0_addr = 32'h20;
        step(0);
        step(0);
        idle_inputs();
        step(0);
        check("t5_rdata0", s_rd0, 32'h11AB_3344);
        check("t5_mem8", mem[8], 32'h11AB_3344);

        // Reset during beat 2 of a locked m1 burst.
        step(1);
        m1_req = 1; m1_lock = 1; m1_addr = 32'h500; m1_wdata = 32'h5555_0001; m1_byteen = 4'hF;
        step(0);
        step(0);
        check("t6_beat1", s_gnt1, 1);
        m1_addr = 32'h504;
        step(1);
        m0_req = 1; m0_addr = 32'h40;
        step(0);
        check("t6_gnt0", s_gnt0, 0);
        check("t6_gnt1", s_gnt1, 0);
        check("t6_rv0", s_rv0, 0);
        check("t6_rv1", s_rv1, 0);
        step(0);
        check("t6_tie_gnt0", s_gnt0, 1);
        check("t6_tie_gnt1", s_gnt1, 0);
        idle_inputs();
        step(0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            m0_req    = $urandom_range(0, 3) != 0;
            m1_req    = $urandom_range(0, 2) != 0;
            m0_lock   = $urandom_range(0, 1) != 0;
            m1_lock   = $urandom_range(0, 3) != 0;
            m0_addr   = ($urandom_range(0, 7) == 0) ? 32'h4000 + ($urandom_range(0, 15) << 2)
                                                    : ($urandom_range(0, 31) << 2);
            m1_addr   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_0000 + $urandom_range(0, 255)
                                                    : ($urandom_range(0, 31) << 2);
            m0_addr[1:0] = 2'($urandom_range(0, 3));
            m0_wdata  = $urandom;
            m1_wdata  = $urandom;
            m0_byteen = $urandom_range(0, 1) != 0 ? 4'h0 : 4'($urandom_range(0, 15));
            m1_byteen = $urandom_range(0, 1) != 0 ? 4'h0 : 4'($urandom_range(0, 15));
            step($urandom_range(0, 299) == 0);
        end
        idle_inputs();
        step(0);
        for (int i = 0; i < 32; i++) check($sformatf("final_mem_%0d", i), mem[i], ref_mem[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
